// File: rtl/min_scan_ctrl_if.sv
// Data-memory bus between the minimum-scan controller and its memory.
//   adr   : byte address
//   d_in  : write data (controller -> memory)
//   d_out : read data (memory -> controller), valid in the same cycle as mrd
//   mrd   : read strobe
//   mwr   : write strobe
// Modports: master (controller side), slave (memory side).
interface min_scan_ctrl_if;
    logic [31:0] adr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        mrd;
    logic        mwr;

    modport master (output adr, output d_in, output mrd, output mwr, input d_out);
    modport slave  (input adr, input d_in, input mrd, input mwr, output d_out);
endinterface

// File: rtl/min_scan_ctrl.sv
// Scans count signed 32-bit words starting at base_adr and finds the minimum
// and its lowest index. It then writes the pair to RESULT_ADR / RESULT_ADR+4
// and pulses done.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a scan (ignored while busy)
//   base_adr, count  : element 0 byte address, number of elements (sampled on start)
//   abort            : only with MIN_SCAN_ABORT_EN; cancels a scan in SCAN
//   busy, done       : not-idle flag, one-cycle completion pulse
//   min_val, min_idx : last completed result
//   mem              : data-memory bus (min_scan_ctrl_if master)
// Optional feature macro: MIN_SCAN_ABORT_EN (adds the abort input).
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | waiting for start
// S_SCAN   | one read per cycle, element i, running minimum update
// S_WR_MIN | write running minimum to RESULT_ADR
// S_WR_IDX | write running index to RESULT_ADR+4, publish result
// S_DONE   | one-cycle done pulse
module min_scan_ctrl #(
    parameter logic [31:0] RESULT_ADR = 32'd2000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] count,
`ifdef MIN_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [31:0]      min_val,
    output logic [31:0]      min_idx,
    min_scan_ctrl_if.master  mem
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_WR_MIN = 3'd2,
        S_WR_IDX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] i_q;
    logic [31:0]      run_min;
    logic [31:0]      run_idx;
    logic [CNT_W-1:0] last_i;

    // Only consulted in SCAN, where cnt_q >= 1 is guaranteed.
    assign last_i = cnt_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (count == '0) ? S_WR_MIN : S_SCAN;
            end
            S_SCAN: begin
                if (i_q == last_i) state_d = S_WR_MIN;
`ifdef MIN_SCAN_ABORT_EN
                if (abort) state_d = S_IDLE;
`endif
            end
            S_WR_MIN: state_d = S_WR_IDX;
            S_WR_IDX: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            run_min <= '0;
            run_idx <= '0;
            min_val <= '0;
            min_idx <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_adr & 32'hFFFF_FFFC;
                        cnt_q   <= count;
                        i_q     <= '0;
                        run_min <= 32'h7FFF_FFFF;
                        run_idx <= 32'hFFFF_FFFF;
                    end
                end
                S_SCAN: begin
                    i_q <= i_q + 1'b1;
                    // Strictly less: ties keep the earliest index.
                    if ($signed(mem.d_out) < $signed(run_min)) begin
                        run_min <= mem.d_out;
                        run_idx <= 32'(i_q);
                    end
                end
                S_WR_IDX: begin
                    min_val <= run_min;
                    min_idx <= run_idx;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs depend only on registers, never on start/abort/d_out.
    always_comb begin
        mem.adr  = '0;
        mem.d_in = '0;
        mem.mrd  = 1'b0;
        mem.mwr  = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        case (state_q)
            S_SCAN: begin
                mem.mrd = 1'b1;
                mem.adr = base_q + (32'(i_q) << 2);
            end
            S_WR_MIN: begin
                mem.mwr  = 1'b1;
                mem.adr  = RESULT_ADR;
                mem.d_in = run_min;
            end
            S_WR_IDX: begin
                mem.mwr  = 1'b1;
                mem.adr  = RESULT_ADR + 32'd4;
                mem.d_in = run_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_min_scan_ctrl.sv
module tb_min_scan_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] count;
    logic        busy, done;
    logic [31:0] min_val, min_idx;
`ifdef MIN_SCAN_ABORT_EN
    logic        abort;
`endif

    min_scan_ctrl_if bus();

    min_scan_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .count    (count),
`ifdef MIN_SCAN_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .min_val  (min_val),
        .min_idx  (min_idx),
        .mem      (bus.master)
    );

    // Memory model: 64 words at 1000..1255; elsewhere a read returns ~adr.
    logic [31:0] mem [0:63];
    logic [31:0] rd_off;
    always_comb begin
        rd_off = bus.adr - 32'd1000;
        if (bus.adr >= 32'd1000 && bus.adr < 32'd1256) bus.d_out = mem[rd_off[7:2]];
        else                                           bus.d_out = ~bus.adr;
    end

    // Result words; the memory does not accept writes while the controller is in reset.
    logic [31:0] res_min = 32'h0;
    logic [31:0] res_idx = 32'h0;
    always @(posedge clk) begin
        if (bus.mwr && !rst) begin
            if (bus.adr == 32'd2000)      res_min = bus.d_in;
            else if (bus.adr == 32'd2004) res_idx = bus.d_in;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] mn;
        logic [31:0] ix;
        int          rd;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] exp_base = 32'h0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int lat = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rd_wr_excl", {31'b0, bus.mrd & bus.mwr}, 32'h0);
            if (bus.mrd) begin
                chk("rd_adr", bus.adr, exp_base + 32'(rd_cnt) * 32'd4);
                rd_cnt++;
            end
            if (bus.mwr) wr_cnt++;
            if (!busy || done) begin
                chk("idle_strobes", {30'b0, bus.mrd, bus.mwr}, 32'h0);
                chk("idle_adr", bus.adr, 32'h0);
                chk("idle_din", bus.d_in, 32'h0);
            end
            if (busy) begin
                if (done) begin
                    done_seen++;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected none pending");
                    end else begin
                        e = sb_q.pop_front();
                        chk("min_val", min_val, e.mn);
                        chk("min_idx", min_idx, e.ix);
                        chk("mem2000", res_min, e.mn);
                        chk("mem2004", res_idx, e.ix);
                        chk("read_count", 32'(rd_cnt), 32'(e.rd));
                        chk("done_latency", 32'(lat), 32'(e.lat));
                    end
                end
                lat++;
            end
        end
    end

    typedef struct {
        logic [31:0]      base;
        int               cnt;
        logic [0:7][31:0] data;
        logic [31:0]      emin;
        logic [31:0]      eidx;
    } vec_t;
    vec_t vecs[8];

    task automatic load_mem(input logic [31:0] base, input logic [0:7][31:0] data);
        logic [31:0] w;
        w = ((base & 32'hFFFF_FFFC) - 32'd1000) >> 2;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            a = w + 32'(k);
            mem[a[5:0]] = data[k];
        end
    endtask

    task automatic run_scan(input logic [31:0] base, input int cnt,
                            input logic [31:0] emin, input logic [31:0] eidx, input int budget);
        exp_t e;
        int   ds;
        int   n;
        @(negedge clk);
        e.mn = emin; e.ix = eidx; e.rd = cnt; e.lat = cnt + 2;
        sb_q.push_back(e);
        exp_base = base & 32'hFFFF_FFFC;
        rd_cnt   = 0;
        lat      = 0;
        ds       = done_seen;
        start    = 1'b1;
        base_adr = base;
        count    = 16'(cnt);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done_seen == ds && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == ds) begin
            total++;
            bad++;
            $display("FAIL scan_timeout: got no done after %0d cycles expected done", budget);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [31:0] old_min, old_idx, old_val;
        int          wr_ref, ds_ref, n;

        for (int k = 0; k < 64; k++) mem[k] = 32'h0;

        vecs[0] = '{32'd1000, 5, {32'd7, 32'hFFFF_FFFD, 32'd12, 32'hFFFF_FFFD, 32'd0, 96'd0},
                    32'hFFFF_FFFD, 32'd1};
        vecs[1] = '{32'd1000, 0, 256'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{32'd1002, 1, {32'd42, 224'd0}, 32'd42, 32'd0};
        vecs[3] = '{32'd1000, 3, {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 160'd0},
                    32'h8000_0000, 32'd0};
        vecs[4] = '{32'd1040, 4, {32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3, 128'd0},
                    32'hFFFF_FFFF, 32'd2};
        vecs[5] = '{32'd1100, 8, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                    32'd1, 32'd7};
        vecs[6] = '{32'd1000, 2, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 192'd0},
                    32'h7FFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{32'd1200, 6, {32'd0, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'hFFFF_FFFB, 64'd0},
                    32'h8000_0000, 32'd2};

        rst = 1'b1; start = 1'b0; base_adr = 32'h0; count = 16'h0;
`ifdef MIN_SCAN_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'b0, busy}, 32'h0);
        chk("rst_done",    {31'b0, done}, 32'h0);
        chk("rst_min_val", min_val, 32'h0);
        chk("rst_min_idx", min_idx, 32'h0);
        chk("rst_adr",     bus.adr, 32'h0);
        chk("rst_din",     bus.d_in, 32'h0);
        chk("rst_strobes", {30'b0, bus.mrd, bus.mwr}, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            load_mem(vecs[v].base, vecs[v].data);
            run_scan(vecs[v].base, vecs[v].cnt, vecs[v].emin, vecs[v].eidx, vecs[v].cnt + 20);
        end

`ifdef MIN_SCAN_ABORT_EN
        // Abort in the third SCAN cycle of a 10-element scan.
        old_val = min_val; old_idx = min_idx; old_min = res_min;
        wr_ref = wr_cnt; ds_ref = done_seen;
        @(negedge clk);
        exp_base = 32'd1000; rd_cnt = 0; lat = 0;
        start = 1'b1; base_adr = 32'd1000; count = 16'd10;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_idle", {31'b0, busy}, 32'h0);
        repeat (4) @(negedge clk);
        chk("abort_reads",   32'(rd_cnt), 32'd3);
        chk("abort_no_wr",   32'(wr_cnt), 32'(wr_ref));
        chk("abort_no_done", 32'(done_seen), 32'(ds_ref));
        chk("abort_min_val", min_val, old_val);
        chk("abort_min_idx", min_idx, old_idx);
        chk("abort_mem2000", res_min, old_min);
`endif

        // Second start during SCAN is ignored; reset in WR_MIN drops both writes.
        load_mem(vecs[0].base, vecs[0].data);
        old_min = res_min; old_idx = res_idx;
        @(negedge clk);
        exp_base = 32'd1000; rd_cnt = 0; lat = 0;
        start = 1'b1; base_adr = 32'd1000; count = 16'd5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; base_adr = 32'd1100; count = 16'd2;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!bus.mwr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_case_reached_wr_min", {31'b0, bus.mwr}, 32'h1);
        chk("rst_case_adr", bus.adr, 32'd2000);
        chk("rst_case_reads", 32'(rd_cnt), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_ref = wr_cnt;
        repeat (5) @(negedge clk);
        chk("rst_case_idle",    {31'b0, busy}, 32'h0);
        chk("rst_case_no_wr",   32'(wr_cnt), 32'(wr_ref));
        chk("rst_case_mem2000", res_min, old_min);
        chk("rst_case_mem2004", res_idx, old_idx);
        chk("rst_case_min_val", min_val, 32'h0);
        chk("rst_case_min_idx", min_idx, 32'h0);

        // Largest count: reads come from ~adr, decreasing, so the last element wins.
        run_scan(32'h0001_0000, 65535, ~(32'h0001_0000 + 32'd4 * 32'd65534), 32'd65534, 65600);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
